// File: rtl/bit_deserializer.sv
// rtl/bit_deserializer.sv - serial-to-parallel word packer with valid/ready output and sticky drop flag
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bit_i,
    input  logic                         bit_valid_i,
    output logic [WIDTH-1:0]             word_o,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt_o,
    output logic                         overflow_o
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_word;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic             r_ovf;

    logic [WIDTH-1:0] w_next_shift;
    logic             w_complete;

    always_comb begin
        w_next_shift = r_shift;
        if (MSB_FIRST)
            w_next_shift = {r_shift[WIDTH-2:0], bit_i};
        else
            w_next_shift = {bit_i, r_shift[WIDTH-1:1]};
        w_complete = bit_valid_i && (r_cnt == CW'(WIDTH-1));
    end

    // The collector never stalls; a full holder without a handshake drops the new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_shift <= '0;
            r_word  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (bit_valid_i) begin
                r_shift <= w_next_shift;
                r_cnt   <= w_complete ? '0 : r_cnt + CW'(1);
            end
            case (r_state)
                S_EMPTY: begin
                    if (w_complete) begin
                        r_word  <= w_next_shift;
                        r_valid <= 1'b1;
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_complete) begin
                        if (word_ready_i)
                            r_word <= w_next_shift;
                        else
                            r_ovf <= 1'b1;
                    end else if (word_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_EMPTY;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    assign word_o       = r_word;
    assign word_valid_o = r_valid;
    assign bit_cnt_o    = r_cnt;
    assign overflow_o   = r_ovf;

endmodule

// File: doc/bit_deserializer.md
# bit_deserializer

Serial-to-parallel stage that consumes the registered single-bit stream produced by the D-FF stage and packs it into WIDTH-bit words. It accepts one qualified bit per cycle, assembles complete words in a shift register, and presents each word on a valid/ready output port. It also flags any word lost because the consumer was not draining.

## Interface
Parameters:
- WIDTH, default 8: bits per word; legal range ≥ 2.
- MSB_FIRST, default 0:
  - 0: the first received bit lands in word_o[0].
  - 1: the first received bit lands in word_o[WIDTH-1].

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- bit_i  input  1  serial data bit (the upstream flop output).
- bit_valid_i  input  1  bit_i is sampled only when this is high.
- word_o  output  WIDTH  assembled word; stable while word_valid_o is high.
- word_valid_o  output  1  word_o holds an undelivered word.
- word_ready_i  input  1  consumer accepts word_o when this and word_valid_o are both high at a rising edge.
- bit_cnt_o  output  $clog2(WIDTH+1)  number of bits currently collected in the partial word (0..WIDTH-1).
- overflow_o  output  1  sticky flag; a completed word was dropped.

## Operation
- Collector: shift register plus bit counter.
  - Each rising edge with bit_valid_i=1 shifts bit_i in and increments the counter.
  - Shift direction per MSB_FIRST:
    - MSB_FIRST=0: register shifts right, new bit enters at WIDTH-1.
    - MSB_FIRST=1: register shifts left, new bit enters at 0.
  - When the accepted bit is the WIDTH-th bit, the word is complete. The counter wraps to 0 on that same edge.
- Output holder has two states, EMPTY and FULL. word_valid_o is 1 exactly in FULL.
  - EMPTY, word completes: load word_o and go to FULL.
  - FULL, handshake (word_ready_i=1) with no completion: go to EMPTY.
  - FULL, handshake and completion in the same edge: load the new word and stay FULL. No loss; word_valid_o stays high.
  - FULL, completion without handshake: drop the new word, set overflow_o, keep the old word_o unchanged, and stay FULL.
- Collector is never stalled. Bits are always accepted; backpressure only causes drops, flagged by overflow_o.
- bit_valid_i=0: no shift and no count change. Gaps of any length between bits are legal.
- word_ready_i while EMPTY is ignored.
- overflow_o stays 1 until reset.

## Timing
- Reset values, effective on the rising edge with reset=1:
  - word_o = 0, word_valid_o = 0, bit_cnt_o = 0, overflow_o = 0.
  - Shift register cleared.
- Reset has priority over every other event on that edge.
- Reset mid-word discards the partial word. The next accepted bit is bit 0 of a new word.
- Latency:
  - If the WIDTH-th bit is accepted at edge N, word_valid_o is high and word_o is valid from edge N onward, i.e. observable in cycle N+1.
  - Handshake at edge M: word_valid_o low after M, unless a new word loaded at M.
- Throughput: one word per WIDTH cycles with continuous bit_valid_i and word_ready_i held high. No bubbles, no drops.
- All outputs are registered. There is no combinational path from any input to any output.
- bit_cnt_o updates on the same edge the bit is accepted.

## Test plan
- Reset then LSB-first word: WIDTH=8, MSB_FIRST=0, word_ready_i=1; feed bits 1,0,1,1,0,0,1,0 on consecutive cycles.
  - word_valid_o rises one cycle after the 8th bit, with word_o=0x4D.
  - bit_cnt_o steps 1..7 then returns to 0.
- MSB-first: same bit sequence with MSB_FIRST=1 → word_o=0xB2.
- Gapped input: the same 8 bits with bit_valid_i low for 3 cycles between every bit → word_o=0x4D. The count must not advance during gaps.
- Backpressure overflow:
  - Hold word_ready_i=0 and send two words, 0x4D then 0xFF.
  - After the second word completes: word_o stays 0x4D, word_valid_o=1, and overflow_o=1 stays set.
  - Raising word_ready_i delivers 0x4D; overflow_o remains 1.
- Simultaneous handshake and completion:
  - Assert word_ready_i on the exact edge the second word 0xA5 completes while 0x4D is held.
  - Required: 0x4D consumed, word_o=0xA5, word_valid_o stays high with no low cycle, overflow_o=0.
- Reset mid-word:
  - Feed 5 bits, pulse reset for one cycle, then feed 1,0,1,1,0,0,1,0.
  - Required: bit_cnt_o=0 after the reset, first output word_o=0x4D, no stale bits.
